roce_host_pkt_parser: RTL and testbench

//  Host-side RoCEv2 receive parser for the simulation bench: consumes FPGA-transmitted frames on a 512b AXIS,

---
 rtl/roce_pkg.sv | 54 +++++
 rtl/roce_rx_psn_tracker.sv | 54 +++++
 rtl/roce_host_pkt_parser.sv | 174 +++++++++++++++++
 tb/tb_roce_host_pkt_parser.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/roce_pkg.sv
// RoCEv2 wire-format constants, parser state type and byte-extraction helpers.
// Shared by the host receive parser and the host packet generator.
package roce_pkg;

    localparam int BEAT_BYTES            = 64;
    localparam int MIN_SINGLE_BEAT_BYTES = 54;

    // Byte offsets into the frame (wire byte 0 = first byte after preamble/SFD)
    localparam int ETH_TYPE_OFF       = 12;
    localparam int IP_VER_IHL_OFF     = 14;
    localparam int IP_PROTO_OFF       = 23;
    localparam int UDP_DPORT_OFF      = 36;
    localparam int BTH_OPCODE_OFF     = 42;
    localparam int BTH_DQP_OFF        = 47;
    localparam int BTH_ACKREQ_OFF     = 50;
    localparam int BTH_PSN_OFF        = 51;
    localparam int AETH_SYND_OFF      = 54;
    localparam int AETH_MSN_OFF       = 55;
    localparam int MAD_ATTR_OFF       = 78;
    localparam int MAD_ATTR_BEAT1_OFF = MAD_ATTR_OFF - BEAT_BYTES;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [15:0] ROCE_UDP_PORT  = 16'd4791;

    localparam logic [7:0]  OP_RC_SEND_ONLY = 8'h04;
    localparam logic [7:0]  OP_RC_ACK       = 8'h11;
    localparam logic [7:0]  OP_UD_SEND_ONLY = 8'h64;

    localparam logic [23:0] GSI_QPN      = 24'd1;
    localparam logic [15:0] CM_ATTR_REP  = 16'h0013;
    localparam logic [15:0] CM_ATTR_DREQ = 16'h0015;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR_OK,
        ST_BODY,
        ST_DROP
    } state_t;

    function automatic logic [7:0] wire_byte(input logic [511:0] d, input int idx);
        return d[8*idx +: 8];
    endfunction

    function automatic logic [15:0] wire_be16(input logic [511:0] d, input int idx);
        return {wire_byte(d, idx), wire_byte(d, idx + 1)};
    endfunction

    function automatic logic [23:0] wire_be24(input logic [511:0] d, input int idx);
        return {wire_byte(d, idx), wire_byte(d, idx + 1), wire_byte(d, idx + 2)};
    endfunction

endpackage

// File: rtl/roce_rx_psn_tracker.sv
// Expected-PSN tracker for a contiguous range of FPGA QPs; psn_err is combinational
// for the presented qpn/psn, state advances only on strobe.
module roce_rx_psn_tracker
    import roce_pkg::*;
#(
    parameter int QP_BASE = 2,
    parameter int NUM_QP  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] qpn,
    input  logic [23:0] psn,
    input  logic        strobe,
    input  logic        clear,
    output logic        psn_err
);

    logic [23:0]       exp_psn [NUM_QP];
    logic [NUM_QP-1:0] seeded;
    logic [NUM_QP-1:0] hit;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        hit     = '0;
        psn_err = 1'b0;
        for (int i = 0; i < NUM_QP; i++) begin
            hit[i] = (qpn == 24'(QP_BASE + i));
            if (hit[i] && seeded[i] && (psn != exp_psn[i]))
                psn_err = 1'b1;
        end
    end

    // A slot is unseeded after reset and after a CM REP/DREQ; its next RC packet seeds it.
    always_ff @(posedge clk) begin
        // NOTE: registered state is always assigned with <= so all flops update from pre-edge values.
        if (rst) begin
            seeded <= '0;
        end else if (clear) begin
            seeded <= '0;
        end else if (strobe) begin
            for (int i = 0; i < NUM_QP; i++)
                if (hit[i]) seeded[i] <= 1'b1;
        end
    end

    // NOTE: exp_psn is storage, not control; it is never reset because the seeded flags gate every read.
    always_ff @(posedge clk) begin
        if (strobe) begin
            for (int i = 0; i < NUM_QP; i++)
                if (hit[i]) exp_psn[i] <= psn + 24'd1;
        end
    end

endmodule

// File: rtl/roce_host_pkt_parser.sv
// Host-side RoCEv2 receive parser: validates Eth/IPv4/UDP/BTH on beat 0, classifies CM vs RC,
// reports fields one clock after tlast and tracks expected PSN per FPGA QP.
module roce_host_pkt_parser
    import roce_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH = 512,
    parameter int QP_BASE           = 2,
    parameter int NUM_QP            = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tlast,
    output logic                           s_axis_tready,
    output logic                           need_ACK,
    output logic [23:0]                    recv_PSN,
    output logic [23:0]                    recv_QPN,
    output logic [7:0]                     rx_opcode,
    output logic [15:0]                    cm_attr_id,
    output logic                           cm_msg_valid,
    output logic                           rc_pkt_valid,
    output logic                           psn_err,
    output logic [15:0]                    drop_cnt,
    output logic [31:0]                    pkt_cnt
);

    state_t      state;
    logic [7:0]  cap_op;
    logic [23:0] cap_qpn;
    logic [23:0] cap_psn;
    logic        cap_ack;
    logic [15:0] cap_attr;

    logic [7:0]  b0_op;
    logic [23:0] b0_qpn;
    logic [23:0] b0_psn;
    logic        b0_ack;
    logic        b0_hdr_ok;
    logic        b0_short;

    logic [7:0]  cur_op;
    logic [23:0] cur_qpn;
    logic [23:0] cur_psn;
    logic        cur_ack;
    logic [15:0] cur_attr;
    logic        cur_is_cm;
    logic        cur_is_rc;

    logic        beat;
    logic        beat_last;
    logic        rep_fire;
    logic        drop_fire;
    logic        cm_clear;
    logic        trk_err;
    logic        unused_tdata;

    assign s_axis_tready = ~rst;
    assign beat          = s_axis_tvalid & s_axis_tready;
    assign beat_last     = beat & s_axis_tlast;
    assign unused_tdata  = ^s_axis_tdata;

    // Beat-0 decode is always live; fields of frames longer than one beat come from the capture regs.
    always_comb begin
        b0_op     = wire_byte(s_axis_tdata, BTH_OPCODE_OFF);
        b0_qpn    = wire_be24(s_axis_tdata, BTH_DQP_OFF);
        b0_psn    = wire_be24(s_axis_tdata, BTH_PSN_OFF);
        b0_ack    = s_axis_tdata[8*BTH_ACKREQ_OFF + 7];
        b0_hdr_ok = (wire_be16(s_axis_tdata, ETH_TYPE_OFF) == ETHERTYPE_IPV4)
                 && (wire_byte(s_axis_tdata, IP_VER_IHL_OFF) == IPV4_VER_IHL)
                 && (wire_byte(s_axis_tdata, IP_PROTO_OFF) == IP_PROTO_UDP)
                 && (wire_be16(s_axis_tdata, UDP_DPORT_OFF) == ROCE_UDP_PORT);
        b0_short  = ($countones(s_axis_tkeep) < MIN_SINGLE_BEAT_BYTES);

        cur_op    = (state == ST_IDLE) ? b0_op  : cap_op;
        cur_qpn   = (state == ST_IDLE) ? b0_qpn : cap_qpn;
        cur_psn   = (state == ST_IDLE) ? b0_psn : cap_psn;
        cur_ack   = (state == ST_IDLE) ? b0_ack : cap_ack;
        cur_attr  = (state == ST_HDR_OK) ? wire_be16(s_axis_tdata, MAD_ATTR_BEAT1_OFF) : cap_attr;
        cur_is_cm = (cur_op == OP_UD_SEND_ONLY) && (cur_qpn == GSI_QPN);
        cur_is_rc = (cur_op[7:5] == 3'b000);

        rep_fire  = 1'b0;
        drop_fire = 1'b0;
        if (beat_last) begin
            case (state)
                ST_IDLE: begin
                    // A CM frame needs beat 1 for its attribute, so a single-beat CM is malformed.
                    if (!b0_hdr_ok || b0_short || cur_is_cm) drop_fire = 1'b1;
                    else                                      rep_fire  = 1'b1;
                end
                ST_HDR_OK, ST_BODY: rep_fire  = 1'b1;
                default:            drop_fire = 1'b1;
            endcase
        end

        cm_clear = rep_fire && cur_is_cm
                && ((cur_attr == CM_ATTR_REP) || (cur_attr == CM_ATTR_DREQ));
    end

    roce_rx_psn_tracker #(
        .QP_BASE (QP_BASE),
        .NUM_QP  (NUM_QP)
    ) u_psn_tracker (
        .clk     (clk),
        .rst     (rst),
        .qpn     (cur_qpn),
        .psn     (cur_psn),
        .strobe  (rep_fire & cur_is_rc),
        .clear   (cm_clear),
        .psn_err (trk_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cap_op       <= '0;
            cap_qpn      <= '0;
            cap_psn      <= '0;
            cap_ack      <= 1'b0;
            cap_attr     <= '0;
            need_ACK     <= 1'b0;
            recv_PSN     <= '0;
            recv_QPN     <= '0;
            rx_opcode    <= '0;
            cm_attr_id   <= '0;
            cm_msg_valid <= 1'b0;
            rc_pkt_valid <= 1'b0;
            psn_err      <= 1'b0;
            drop_cnt     <= '0;
            pkt_cnt      <= '0;
        end else begin
            rc_pkt_valid <= rep_fire & cur_is_rc;
            need_ACK     <= rep_fire & cur_is_rc & cur_ack;
            psn_err      <= rep_fire & cur_is_rc & trk_err;
            cm_msg_valid <= rep_fire & cur_is_cm;

            if (rep_fire) begin
                recv_QPN  <= cur_qpn;
                rx_opcode <= cur_op;
                pkt_cnt   <= pkt_cnt + 32'd1;
                if (cur_is_rc) recv_PSN   <= cur_psn;
                if (cur_is_cm) cm_attr_id <= cur_attr;
            end

            if (drop_fire && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;

            if (beat) begin
                case (state)
                    ST_IDLE: begin
                        if (!s_axis_tlast) begin
                            state   <= b0_hdr_ok ? ST_HDR_OK : ST_DROP;
                            cap_op  <= b0_op;
                            cap_qpn <= b0_qpn;
                            cap_psn <= b0_psn;
                            cap_ack <= b0_ack;
                        end
                    end
                    ST_HDR_OK: begin
                        cap_attr <= cur_attr;
                        state    <= s_axis_tlast ? ST_IDLE : ST_BODY;
                    end
                    ST_BODY, ST_DROP: begin
                        if (s_axis_tlast) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_roce_host_pkt_parser.sv
// Scoreboard bench for roce_host_pkt_parser: each frame's expected report is queued when its
// tlast beat is driven and compared by a monitor when the DUT pulses rc/cm valid.
module tb_roce_host_pkt_parser;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] s_axis_tdata;
    logic [63:0]  s_axis_tkeep;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic         need_ACK;
    logic [23:0]  recv_PSN;
    logic [23:0]  recv_QPN;
    logic [7:0]   rx_opcode;
    logic [15:0]  cm_attr_id;
    logic         cm_msg_valid;
    logic         rc_pkt_valid;
    logic         psn_err;
    logic [15:0]  drop_cnt;
    logic [31:0]  pkt_cnt;

    typedef struct {
        bit          is_cm;
        logic [23:0] qpn;
        logic [23:0] psn;
        logic [7:0]  op;
        logic [15:0] attr;
        bit          ack;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        m;
    logic [7:0]  fr [0:319];
    int          cyc      = 0;
    int          checks   = 0;
    int          errors   = 0;
    int          exp_pkt  = 0;
    int          exp_drop = 0;
    int          rc_seen  = 0;
    bit          started  = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    roce_host_pkt_parser #(
        .C_AXIS_DATA_WIDTH (512),
        .QP_BASE           (2),
        .NUM_QP            (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .need_ACK      (need_ACK),
        .recv_PSN      (recv_PSN),
        .recv_QPN      (recv_QPN),
        .rx_opcode     (rx_opcode),
        .cm_attr_id    (cm_attr_id),
        .cm_msg_valid  (cm_msg_valid),
        .rc_pkt_valid  (rc_pkt_valid),
        .psn_err       (psn_err),
        .drop_cnt      (drop_cnt),
        .pkt_cnt       (pkt_cnt)
    );

    // Output monitor: every class pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (started && (rc_pkt_valid || cm_msg_valid)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: rc=%0b cm=%0b qpn=%0h, expected no report", rc_pkt_valid, cm_msg_valid, recv_QPN);
            end else begin
                m = sb.pop_front();
                if (rc_pkt_valid) rc_seen++;
                if ({rc_pkt_valid, cm_msg_valid} !== {!m.is_cm, m.is_cm}) begin
                    errors++;
                    $display("FAIL class: rc=%0b cm=%0b, expected rc=%0b cm=%0b", rc_pkt_valid, cm_msg_valid, !m.is_cm, m.is_cm);
                end
                checks++;
                if (need_ACK !== (!m.is_cm && m.ack)) begin
                    errors++;
                    $display("FAIL need_ack: got %0b expected %0b", need_ACK, (!m.is_cm && m.ack));
                end
                checks++;
                if (psn_err !== (!m.is_cm && m.err)) begin
                    errors++;
                    $display("FAIL psn_err: got %0b expected %0b (psn %0h)", psn_err, (!m.is_cm && m.err), m.psn);
                end
                checks++;
                if (recv_QPN !== m.qpn || rx_opcode !== m.op || recv_PSN !== m.psn) begin
                    errors++;
                    $display("FAIL fields: qpn/op/psn got %0h/%0h/%0h expected %0h/%0h/%0h",
                             recv_QPN, rx_opcode, recv_PSN, m.qpn, m.op, m.psn);
                end
                if (m.is_cm) begin
                    checks++;
                    if (cm_attr_id !== m.attr) begin
                        errors++;
                        $display("FAIL cm_attr: got %0h expected %0h", cm_attr_id, m.attr);
                    end
                end
                checks++;
                if (cyc !== m.cyc) begin
                    errors++;
                    $display("FAIL latency: report at cycle %0d expected cycle %0d", cyc, m.cyc);
                end
            end
        end else if (started && (need_ACK || psn_err)) begin
            checks++;
            errors++;
            $display("FAIL stray_pulse: need_ACK=%0b psn_err=%0b without rc_pkt_valid, expected 0", need_ACK, psn_err);
        end
    end

    task automatic build(input logic [7:0] op, input logic [23:0] qpn, input logic [23:0] psn,
                         input bit ack, input logic [15:0] dport, input logic [15:0] attr);
        for (int i = 0; i < 320; i++) fr[i] = 8'($urandom);
        fr[12] = 8'h08;  fr[13] = 8'h00;
        fr[14] = 8'h45;  fr[23] = 8'h11;
        fr[36] = dport[15:8]; fr[37] = dport[7:0];
        fr[42] = op;
        fr[47] = qpn[23:16]; fr[48] = qpn[15:8]; fr[49] = qpn[7:0];
        fr[50] = {ack, fr[50][6:0]};
        fr[51] = psn[23:16]; fr[52] = psn[15:8]; fr[53] = psn[7:0];
        fr[78] = attr[15:8]; fr[79] = attr[7:0];
    endtask

    // Drives fr[0:len-1]; gap_beat >= 1 inserts one tvalid-low cycle before that beat.
    task automatic send_frame(input int len, input int gap_beat, input bit push, input exp_t e);
        int nb;
        nb = (len + 63) / 64;
        for (int b = 0; b < nb; b++) begin
            if (b == gap_beat) begin
                @(negedge clk);
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b1;
                s_axis_tdata  = {16{$urandom}};
            end
            @(negedge clk);
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (b == nb - 1);
            for (int i = 0; i < 64; i++) begin
                s_axis_tdata[8*i +: 8] = (b*64 + i < len) ? fr[b*64 + i] : 8'h00;
                s_axis_tkeep[i]        = (b < nb - 1) || (b*64 + i < len);
            end
            if (b == nb - 1 && push) begin
                e.cyc = cyc + 1;
                sb.push_back(e);
            end
        end
    endtask

    task automatic send_rc(input logic [23:0] qpn, input logic [23:0] psn, input bit ack,
                           input bit err, input int len, input int gap);
        exp_t e;
        build(8'h04, qpn, psn, ack, 16'd4791, 16'h0000);
        e.is_cm = 1'b0; e.qpn = qpn; e.psn = psn; e.op = 8'h04;
        e.attr = 16'h0; e.ack = ack; e.err = err; e.cyc = 0;
        send_frame(len, gap, 1'b1, e);
        exp_pkt++;
    endtask

    task automatic send_cm(input logic [15:0] attr, input int len, input logic [23:0] held_psn);
        exp_t e;
        build(8'h64, 24'd1, 24'h000000, 1'b1, 16'd4791, attr);
        e.is_cm = 1'b1; e.qpn = 24'd1; e.psn = held_psn; e.op = 8'h64;
        e.attr = attr; e.ack = 1'b0; e.err = 1'b0; e.cyc = 0;
        send_frame(len, -1, 1'b1, e);
        exp_pkt++;
    endtask

    task automatic wait_drain();
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d reports outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_counts(input string tag);
        checks++;
        if (pkt_cnt !== 32'(exp_pkt) || drop_cnt !== 16'(exp_drop)) begin
            errors++;
            $display("FAIL counts_%s: pkt_cnt=%0d drop_cnt=%0d expected %0d/%0d", tag, pkt_cnt, drop_cnt, exp_pkt, exp_drop);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        s_axis_tdata = '0;    s_axis_tkeep = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL tready_in_reset: got %0b expected 0", s_axis_tready);
        end
        checks++;
        if ({need_ACK, recv_PSN, recv_QPN, rx_opcode, cm_attr_id, cm_msg_valid,
             rc_pkt_valid, psn_err, drop_cnt, pkt_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: psn=%0h qpn=%0h op=%0h pkt=%0d drop=%0d, expected all 0",
                     recv_PSN, recv_QPN, rx_opcode, pkt_cnt, drop_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL tready_after_reset: got %0b expected 1", s_axis_tready);
        end
        started = 1'b1;
    endtask

    task automatic test_rc_send();
        send_rc(24'd2, 24'h000100, 1'b1, 1'b0, 100, -1);
        wait_drain();
        check_counts("rc_send");
    endtask

    task automatic test_psn_sequence();
        send_rc(24'd2, 24'h000101, 1'b0, 1'b0, 128, -1);
        send_rc(24'd2, 24'h000103, 1'b1, 1'b1, 70,  -1);
        send_rc(24'd2, 24'h000104, 1'b0, 1'b0, 200, -1);
        wait_drain();
        check_counts("psn_seq");
    endtask

    task automatic test_cm_reseed();
        send_cm(16'h0013, 300, 24'h000104);
        send_rc(24'd2, 24'h00ABCD, 1'b1, 1'b0, 100, -1);
        send_rc(24'd2, 24'h00ABCF, 1'b1, 1'b1, 100, -1);
        wait_drain();
        check_counts("cm_reseed");
        checks++;
        if (cm_attr_id !== 16'h0013) begin
            errors++;
            $display("FAIL cm_attr_held: got %0h expected 0013", cm_attr_id);
        end
    endtask

    task automatic test_drop();
        exp_t none;
        none.is_cm = 1'b0; none.qpn = '0; none.psn = '0; none.op = '0;
        none.attr = '0; none.ack = 1'b0; none.err = 1'b0; none.cyc = 0;
        build(8'h04, 24'd2, 24'h000200, 1'b1, 16'd4790, 16'h0);
        send_frame(100, -1, 1'b0, none);
        exp_drop++;
        build(8'h04, 24'd2, 24'h000200, 1'b1, 16'd4791, 16'h0);
        send_frame(40, -1, 1'b0, none);
        exp_drop++;
        wait_drain();
        check_counts("drop_two");
        build(8'h64, 24'd1, 24'h0, 1'b0, 16'd4791, 16'h0013);
        send_frame(64, -1, 1'b0, none);
        exp_drop++;
        send_rc(24'd5, 24'h000010, 1'b1, 1'b0, 54, -1);
        send_rc(24'd5, 24'h000900, 1'b0, 1'b0, 54, -1);
        build(8'h64, 24'd7, 24'h000033, 1'b1, 16'd4791, 16'h0);
        send_frame(128, -1, 1'b0, none);
        exp_pkt++;
        wait_drain();
        check_counts("drop_boundary");
        checks++;
        if (recv_QPN !== 24'd7 || rx_opcode !== 8'h64 || recv_PSN !== 24'h000900) begin
            errors++;
            $display("FAIL other_opcode: qpn/op/psn got %0h/%0h/%0h expected 7/64/900", recv_QPN, rx_opcode, recv_PSN);
        end
    endtask

    task automatic test_back_to_back();
        int rc0;
        rc0 = rc_seen;
        send_rc(24'd3, 24'hFFFFFF, 1'b1, 1'b0, 100, -1);
        send_rc(24'd3, 24'h000000, 1'b1, 1'b0, 100, 1);
        send_rc(24'd3, 24'h000001, 1'b0, 1'b0, 60,  -1);
        send_rc(24'd4, 24'h123456, 1'b1, 1'b0, 60,  -1);
        wait_drain();
        check_counts("back_to_back");
        checks++;
        if (rc_seen - rc0 !== 4) begin
            errors++;
            $display("FAIL rc_pulse_count: got %0d expected 4", rc_seen - rc0);
        end
    endtask

    initial begin
        test_reset();
        test_rc_send();
        test_psn_sequence();
        test_cm_reseed();
        test_drop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
